serial_word_deser: RTL and testbench

Serial-to-parallel front end that feeds the data input of the team's `dff` register stage. It collects one bit per qualified clock into a `BITS_COUNT`-bit word and presents each completed word through a valid/ready holding register. The shift register and the holding register are separate, so a serial stream can continue while the consumer drains the previous word. When `dff` consumes the word directly, `word_ready` is tied high.

---
 rtl/dffx_pkg.sv | 13 +
 rtl/serial_word_deser_bit_counter.sv | 42 ++++
 rtl/serial_word_deser.sv | 95 +++++++++
 tb/tb_serial_word_deser.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dffx_pkg.sv
// Shared definitions for the dff register stage and its serial front end.
// Holds the default word width and the deserializer's debug state type.
package dffx;

  localparam int dff_bits_count = 8;
  localparam int deser_cnt_w    = $clog2(dff_bits_count);

  typedef enum logic {
    DESER_IDLE  = 1'b0,
    DESER_SHIFT = 1'b1
  } deser_state_e;

endpackage

// File: rtl/serial_word_deser_bit_counter.sv
// Modulo-BITS_COUNT bit counter for the serial deserializer.
// Priority is load1 > clr > inc; last flags the final bit position of a word.
module deser_bit_counter
  import dffx::*;
#(
  parameter int  BITS_COUNT = dff_bits_count,
  localparam int CW         = $clog2(BITS_COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic         last,
  output deser_state_e state
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last  = (cnt_q == CW'(BITS_COUNT - 1));
  assign state = (cnt_q == '0) ? DESER_IDLE : DESER_SHIFT;

  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = CW'(1);
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_deser.sv
// Serial-to-parallel front end: shifts one bit per qualified clock into a word
// and hands completed words to the consumer through a valid/ready holding register.
module serial_word_deser
  import dffx::*;
#(
  parameter int BITS_COUNT = dff_bits_count,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sin,
  input  logic                  sin_valid,
  input  logic                  sync,
  output logic [BITS_COUNT-1:0] word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
);

  if (BITS_COUNT < 2) begin : g_bad_width
    $error("serial_word_deser: BITS_COUNT must be at least 2");
  end

  logic [BITS_COUNT-1:0] shift_q, shift_d, shift_base, shift_in;
  logic [BITS_COUNT-1:0] word_q, word_d;
  logic                  word_valid_q, word_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  last, complete, hold_free;
  deser_state_e          state;

  deser_bit_counter #(
    .BITS_COUNT(BITS_COUNT)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (sin_valid & ~sync),
    .clr   (sync & ~sin_valid),
    .load1 (sync & sin_valid),
    .last  (last),
    .state (state)
  );

  // A resync with a valid bit starts the new word from an empty register.
  assign shift_base = sync ? '0 : shift_q;
  assign shift_in   = MSB_FIRST ? {shift_base[BITS_COUNT-2:0], sin}
                                : {sin, shift_base[BITS_COUNT-1:1]};

  assign complete  = sin_valid & ~sync & last;
  assign hold_free = ~word_valid_q | word_ready;

  always_comb begin
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = word_valid_q & ~word_ready;
    overrun_d    = overrun_q & ~overrun_clr;

    if (sync && !sin_valid) begin
      shift_d = '0;
    end else if (sin_valid) begin
      shift_d = complete ? '0 : shift_in;
    end

    // A drop overrides a same-edge clear so no overrun is ever lost.
    if (complete) begin
      if (hold_free) begin
        word_d       = shift_in;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state == DESER_SHIFT);

endmodule

// File: tb/tb_serial_word_deser.sv
// Bench for serial_word_deser: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a bit-queue reference model.
module tb_serial_word_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sin = 1'b0, sin_valid = 1'b0, sync = 1'b0;
  logic word_ready = 1'b0, overrun_clr = 1'b0;

  logic [W-1:0] word_m, word_l;
  logic         valid_m, valid_l, over_m, over_l, busy_m, busy_l;

  serial_word_deser #(.BITS_COUNT(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .word(word_m), .word_valid(valid_m), .word_ready(word_ready),
    .overrun(over_m), .overrun_clr(overrun_clr), .busy(busy_m)
  );

  serial_word_deser #(.BITS_COUNT(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .word(word_l), .word_valid(valid_l), .word_ready(word_ready),
    .overrun(over_l), .overrun_clr(overrun_clr), .busy(busy_l)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_xfer   = 0;
  string phase    = "reset";

  // Reference model: received bits of the partial word in arrival order.
  bit           mq[$];
  logic [W-1:0] m_word_m = '0, m_word_l = '0;
  bit           m_valid = 1'b0, m_over = 1'b0;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_word_m = '0;
    m_word_l = '0;
    m_valid  = 1'b0;
    m_over   = 1'b0;
  endtask

  task automatic model_step();
    bit           free, xfer, load, drop;
    logic [W-1:0] wm, wl;
    if (rst) begin
      model_reset();
      return;
    end
    free = !m_valid || word_ready;
    xfer = m_valid && word_ready;
    load = 1'b0;
    drop = 1'b0;
    wm   = '0;
    wl   = '0;
    if (xfer) begin
      $display("xfer %0d [%s]: word_m=%02h word_l=%02h", n_xfer, phase, m_word_m, m_word_l);
      n_xfer++;
    end
    if (sync) begin
      mq.delete();
      if (sin_valid) mq.push_back(sin);
    end else if (sin_valid) begin
      mq.push_back(sin);
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mq[i];
          wl[i]     = mq[i];
        end
        mq.delete();
        if (free) begin
          m_word_m = wm;
          m_word_l = wl;
          load     = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    if (load) m_valid = 1'b1;
    else if (xfer) m_valid = 1'b0;
    if (drop) m_over = 1'b1;
    else if (overrun_clr) m_over = 1'b0;
  endtask

  task automatic compare_all();
    check("word_m",  word_m,  m_word_m);
    check("word_l",  word_l,  m_word_l);
    check("valid_m", 8'(valid_m), 8'(m_valid));
    check("valid_l", 8'(valid_l), 8'(m_valid));
    check("over_m",  8'(over_m),  8'(m_over));
    check("over_l",  8'(over_l),  8'(m_over));
    check("busy_m",  8'(busy_m),  8'(mq.size() != 0));
    check("busy_l",  8'(busy_l),  8'(mq.size() != 0));
  endtask

  task automatic cycle(bit v, bit s, bit sy, bit rdy, bit clr);
    sin_valid   = v;
    sin         = s;
    sync        = sy;
    word_ready  = rdy;
    overrun_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_word(logic [7:0] w, bit rdy, bit clr_last);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, w[i], 1'b0, rdy, (i == 0) ? clr_last : 1'b0);
    end
  endtask

  initial begin
    #1;
    compare_all();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0);

    phase = "a5";
    send_word(8'hA5, 1'b1, 1'b0);
    check("direct_word", word_m, 8'hA5);
    check("direct_valid", 8'(valid_m), 8'h01);
    cycle(0, 0, 0, 1, 0);
    check("direct_valid_drop", 8'(valid_m), 8'h00);
    check("direct_over", 8'(over_m), 8'h00);

    phase = "lsb01";
    send_word(8'h80, 1'b1, 1'b0);
    check("direct_word_l", word_l, 8'h01);
    cycle(0, 0, 0, 1, 0);

    phase = "overrun";
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    check("direct_word", word_m, 8'h3C);
    check("direct_over", 8'(over_m), 8'h01);
    cycle(0, 0, 0, 1, 0);
    check("direct_valid", 8'(valid_m), 8'h00);
    cycle(0, 0, 0, 0, 1);
    check("direct_over_clr", 8'(over_m), 8'h00);

    phase = "sync";
    for (int i = 0; i < 5; i++) cycle(1, 1'($urandom_range(0, 1)), 0, 1, 0);
    cycle(1, 1, 1, 1, 0);
    for (int i = 6; i >= 0; i--) cycle(1, (i == 0), 0, 1, 0);
    check("direct_word", word_m, 8'h81);
    check("direct_valid", 8'(valid_m), 8'h01);
    check("direct_over", 8'(over_m), 8'h00);
    cycle(0, 0, 0, 1, 0);

    phase = "async_rst";
    send_word(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("direct_word", word_m, 8'h00);
    cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
    send_word(8'hFF, 1'b1, 1'b0);
    check("direct_word", word_m, 8'hFF);
    cycle(0, 0, 0, 1, 0);

    phase = "clr_vs_set";
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    check("direct_over_set_wins", 8'(over_m), 8'h01);
    cycle(0, 0, 0, 0, 1);
    check("direct_over_clr", 8'(over_m), 8'h00);
    cycle(0, 0, 0, 1, 0);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
